fp_mul_pipe: RTL

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe_if.sv | 24 ++
 rtl/fp_mul_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe_if.sv
// Operand/result bundle for fp_mul_pipe; flags only exist when FP_MUL_FLAGS_EN is defined.
// Master drives en/in_valid/a/b; slave returns out_valid/q (and flags).
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic         en;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] q;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]   flags;

    modport master (output en, in_valid, a, b, input out_valid, q, flags);
    modport slave  (input en, in_valid, a, b, output out_valid, q, flags);
`else
    modport master (output en, in_valid, a, b, input out_valid, q);
    modport slave  (input en, in_valid, a, b, output out_valid, q);
`endif
endinterface

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier, RNE rounding, subnormals flushed; FP_MUL_FLAGS_EN adds {invalid,overflow,underflow,inexact}.
// Latency: LATENCY enabled cycles (2..6); stage 1 decodes and multiplies, stage 2 rounds/packs, rest is delay.
// No backpressure: one pair per enabled cycle; en=0 freezes every stage including q/out_valid.
module fp_mul_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 3
) (
    input  logic         clk,
    input  logic         areset_n,
    fp_mul_pipe_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    // ---------------- stage 1: classify, add exponents, multiply ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    cls_t             cls_d;
    logic signed [XW-1:0] exp_d;
    logic [PW-1:0]    prod_d;

    assign {sa, ea, fa} = io.a;
    assign {sb, eb, fb} = io.b;
    assign a_max  = &ea;
    assign b_max  = &eb;
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_nan  = a_max & (|fa);
    assign b_nan  = b_max & (|fb);
    assign a_inf  = a_max & ~(|fa);
    assign b_inf  = b_max & ~(|fb);

    always_comb begin
        cls_d = CLS_NUM;
        if (a_nan | b_nan)
            cls_d = CLS_NAN;
        else if ((a_inf & b_zero) | (b_inf & a_zero))
            cls_d = CLS_NAN;
        else if (a_inf | b_inf)
            cls_d = CLS_INF;
        else if (a_zero | b_zero)
            cls_d = CLS_ZERO;
    end

    assign exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    assign prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

`ifdef FP_MUL_FLAGS_EN
    logic inv_d;
    // Only signalling NaNs (quiet bit clear) or inf*0 raise invalid.
    assign inv_d = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]) |
                   (~(a_nan | b_nan) & ((a_inf & b_zero) | (b_inf & a_zero)));
    logic s1_inv;
`endif

    logic                 s1_vld;
    logic                 s1_sign;
    cls_t                 s1_cls;
    logic signed [XW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_cls  <= CLS_ZERO;
            s1_exp  <= '0;
            s1_prod <= '0;
`ifdef FP_MUL_FLAGS_EN
            s1_inv  <= 1'b0;
`endif
        end else if (io.en) begin
            s1_vld <= io.in_valid;
            if (io.in_valid) begin
                s1_sign <= sa ^ sb;
                s1_cls  <= cls_d;
                s1_exp  <= exp_d;
                s1_prod <= prod_d;
`ifdef FP_MUL_FLAGS_EN
                s1_inv  <= inv_d;
`endif
            end
        end
    end

    // ---------------- stage 2: normalise, round to nearest even, pack ----------------
    logic                 top;
    logic [PW-2:0]        pn;
    logic [MAN_W-1:0]     fld, man_r;
    logic                 grd, stk, rup, carry;
    logic signed [XW-1:0] exp_n;
    logic                 ovf, unf;
    logic [W-1:0]         r_q;

    // pn drops the always-set hidden bit so only the stored field and round bits remain.
    assign top   = s1_prod[PW-1];
    assign pn    = top ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
    assign fld   = pn[PW-2 -: MAN_W];
    assign grd   = pn[MAN_W];
    assign stk   = |pn[MAN_W-1:0];
    assign rup   = grd & (stk | fld[0]);
    assign man_r = fld + MAN_W'(rup);
    assign carry = rup & (&fld);
    assign exp_n = s1_exp + $signed({{(XW-1){1'b0}}, top}) + $signed({{(XW-1){1'b0}}, carry});
    assign ovf   = (s1_cls == CLS_NUM) && (exp_n >= EMAX);
    assign unf   = (s1_cls == CLS_NUM) && (exp_n <= EZERO);

    always_comb begin
        r_q = {s1_sign, {(W-1){1'b0}}};
        case (s1_cls)
            CLS_NAN:  r_q = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            CLS_INF:  r_q = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: r_q = {s1_sign, {(W-1){1'b0}}};
            default: begin
                if (ovf)
                    r_q = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (unf)
                    r_q = {s1_sign, {(W-1){1'b0}}};
                else
                    r_q = {s1_sign, exp_n[EXP_W-1:0], man_r};
            end
        endcase
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] r_f;
    assign r_f = {s1_inv, ovf, unf, ovf | unf | ((s1_cls == CLS_NUM) & (grd | stk))};
    logic [3:0] c_f [LATENCY-1];
`endif

    // ---------------- delay stages; data only moves with a valid so q holds between results ----------------
    logic [LATENCY-2:0] c_vld;
    logic [W-1:0]       c_q [LATENCY-1];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            c_vld <= '0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                c_q[i] <= '0;
`ifdef FP_MUL_FLAGS_EN
                c_f[i] <= '0;
`endif
            end
        end else if (io.en) begin
            c_vld[0] <= s1_vld;
            if (s1_vld) begin
                c_q[0] <= r_q;
`ifdef FP_MUL_FLAGS_EN
                c_f[0] <= r_f;
`endif
            end
            for (int i = 1; i < LATENCY - 1; i++) begin
                c_vld[i] <= c_vld[i-1];
                if (c_vld[i-1]) begin
                    c_q[i] <= c_q[i-1];
`ifdef FP_MUL_FLAGS_EN
                    c_f[i] <= c_f[i-1];
`endif
                end
            end
        end
    end

    assign io.out_valid = c_vld[LATENCY-2];
    assign io.q         = c_q[LATENCY-2];
`ifdef FP_MUL_FLAGS_EN
    assign io.flags     = c_f[LATENCY-2];
`endif
endmodule
